// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline stall unit: no-op encodings and the
// watchdog state encoding.
package pipeline_pkg;

    // sll $0,$0,0 -- the all-zero word the IF/ID register takes on a flush
    localparam logic [31:0] NOP_INSTR = 32'h0;

    // One bit of the no-op control bundle; the bundle is this bit replicated
    localparam logic CTRL_NOP = 1'b0;

    // Watchdog states
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        HUNG  = 2'd2
    } stall_state_e;

endpackage

// File: rtl/pipeline_stall_unit_stall_watchdog.sv
// Stall watchdog: tracks how many consecutive cycles some stall is asserted
// and latches a sticky timeout once that run reaches MAX_STALL.
module stall_watchdog
    import pipeline_pkg::*;
#(
    parameter int MAX_STALL = 15
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Stall_Any,
    output logic Stall_Timeout
);

    localparam int RW = (MAX_STALL < 2) ? 1 : $clog2(MAX_STALL + 1);
    localparam logic [RW-1:0] MaxLen = RW'(MAX_STALL);

    stall_state_e  state_q, state_d;
    logic [RW-1:0] runLen_q, runLen_d;
    logic [RW-1:0] runInc;

    // Next-state and run-length update; HUNG is absorbing until reset
    always_comb begin
        state_d  = state_q;
        runLen_d = runLen_q;
        runInc   = runLen_q + RW'(1);
        case (state_q)
            RUN: begin
                if (Stall_Any) begin
                    runLen_d = RW'(1);
                    state_d  = (MAX_STALL == 1) ? HUNG : STALL;
                end
            end
            STALL: begin
                if (!Stall_Any) begin
                    state_d  = RUN;
                    runLen_d = '0;
                end else begin
                    runLen_d = runInc;
                    if (runInc == MaxLen) begin
                        state_d = HUNG;
                    end
                end
            end
            HUNG: begin
                state_d = HUNG;
            end
            default: begin
                state_d  = RUN;
                runLen_d = '0;
            end
        endcase
    end

    // State and run-length registers with synchronous reset
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= RUN;
            runLen_q <= '0;
        end else begin
            state_q  <= state_d;
            runLen_q <= runLen_d;
        end
    end

    assign Stall_Timeout = (state_q == HUNG);

endmodule

// File: rtl/pipeline_stall_unit.sv
// Pipeline stall unit: applies hazard stalls and the ID branch flush to the
// IF/ID register and the ID/EX control register, and counts stall, bubble
// and flush events.
module pipeline_stall_unit
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 16,
    parameter int CNT_WIDTH  = 32,
    parameter int MAX_STALL  = 15
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Stall_PC,
    input  logic                  Stall_ID,
    input  logic                  Stall_ID_EX,
    input  logic                  Branch_Taken,
    input  logic [DATA_WIDTH-1:0] IF_Instruction,
    input  logic [DATA_WIDTH-1:0] IF_PCPlus4,
    input  logic [CTRL_WIDTH-1:0] ID_Ctrl,
    output logic                  PC_Write,
    output logic [DATA_WIDTH-1:0] ID_Instruction,
    output logic [DATA_WIDTH-1:0] ID_PCPlus4,
    output logic [CTRL_WIDTH-1:0] EX_Ctrl,
    output logic [CNT_WIDTH-1:0]  Stall_Count,
    output logic [CNT_WIDTH-1:0]  Bubble_Count,
    output logic [CNT_WIDTH-1:0]  Flush_Count,
    output logic                  Stall_Timeout
);

    logic [DATA_WIDTH-1:0] idInstr_q, idInstr_d;
    logic [DATA_WIDTH-1:0] idPc4_q, idPc4_d;
    logic [CTRL_WIDTH-1:0] exCtrl_q, exCtrl_d;
    logic [CNT_WIDTH-1:0]  stallCnt_q, stallCnt_d;
    logic [CNT_WIDTH-1:0]  bubbleCnt_q, bubbleCnt_d;
    logic [CNT_WIDTH-1:0]  flushCnt_q, flushCnt_d;
    logic                  flushTaken;

    // A stalled IF/ID wins over a taken branch: the branch operand is not ready
    assign flushTaken = Branch_Taken && !Stall_ID;

    assign PC_Write = !Reset && !Stall_PC;

    // Next values for the pipeline registers and the saturating event counters
    always_comb begin
        idInstr_d   = idInstr_q;
        idPc4_d     = idPc4_q;
        exCtrl_d    = Stall_ID_EX ? {CTRL_WIDTH{CTRL_NOP}} : ID_Ctrl;
        stallCnt_d  = stallCnt_q;
        bubbleCnt_d = bubbleCnt_q;
        flushCnt_d  = flushCnt_q;
        if (!Stall_ID) begin
            if (Branch_Taken) begin
                idInstr_d = DATA_WIDTH'(NOP_INSTR);
                idPc4_d   = '0;
            end else begin
                idInstr_d = IF_Instruction;
                idPc4_d   = IF_PCPlus4;
            end
        end
        if (Stall_PC && (stallCnt_q != '1)) begin
            stallCnt_d = stallCnt_q + CNT_WIDTH'(1);
        end
        if (Stall_ID_EX && (bubbleCnt_q != '1)) begin
            bubbleCnt_d = bubbleCnt_q + CNT_WIDTH'(1);
        end
        if (flushTaken && (flushCnt_q != '1)) begin
            flushCnt_d = flushCnt_q + CNT_WIDTH'(1);
        end
    end

    // Pipeline and counter registers; reset overrides every input that cycle
    always_ff @(posedge Clock) begin
        if (Reset) begin
            idInstr_q   <= '0;
            idPc4_q     <= '0;
            exCtrl_q    <= '0;
            stallCnt_q  <= '0;
            bubbleCnt_q <= '0;
            flushCnt_q  <= '0;
        end else begin
            idInstr_q   <= idInstr_d;
            idPc4_q     <= idPc4_d;
            exCtrl_q    <= exCtrl_d;
            stallCnt_q  <= stallCnt_d;
            bubbleCnt_q <= bubbleCnt_d;
            flushCnt_q  <= flushCnt_d;
        end
    end

    assign ID_Instruction = idInstr_q;
    assign ID_PCPlus4     = idPc4_q;
    assign EX_Ctrl        = exCtrl_q;
    assign Stall_Count    = stallCnt_q;
    assign Bubble_Count   = bubbleCnt_q;
    assign Flush_Count    = flushCnt_q;

    stall_watchdog #(
        .MAX_STALL(MAX_STALL)
    ) uWatchdog (
        .Clock        (Clock),
        .Reset        (Reset),
        .Stall_Any    (Stall_PC | Stall_ID | Stall_ID_EX),
        .Stall_Timeout(Stall_Timeout)
    );

endmodule

// File: tb/tb_pipeline_stall_unit.sv
// Directed bench for pipeline_stall_unit: a default instance and a narrow
// instance (4-bit counters, one-cycle watchdog) share the same stimulus.
module tb_pipeline_stall_unit;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Stall_PC, Stall_ID, Stall_ID_EX, Branch_Taken;
    logic [31:0] IF_Instruction, IF_PCPlus4;
    logic [15:0] ID_Ctrl;

    logic        pcWrite0, timeout0;
    logic [31:0] idInstr0, idPc40, stallCnt0, bubbleCnt0, flushCnt0;
    logic [15:0] exCtrl0;

    logic        pcWrite1, timeout1;
    logic [31:0] idInstr1, idPc41;
    logic [15:0] exCtrl1;
    logic [3:0]  stallCnt1, bubbleCnt1, flushCnt1;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    pipeline_stall_unit dut0 (
        .Clock(Clock), .Reset(Reset),
        .Stall_PC(Stall_PC), .Stall_ID(Stall_ID), .Stall_ID_EX(Stall_ID_EX),
        .Branch_Taken(Branch_Taken),
        .IF_Instruction(IF_Instruction), .IF_PCPlus4(IF_PCPlus4), .ID_Ctrl(ID_Ctrl),
        .PC_Write(pcWrite0), .ID_Instruction(idInstr0), .ID_PCPlus4(idPc40),
        .EX_Ctrl(exCtrl0), .Stall_Count(stallCnt0), .Bubble_Count(bubbleCnt0),
        .Flush_Count(flushCnt0), .Stall_Timeout(timeout0)
    );

    pipeline_stall_unit #(.CNT_WIDTH(4), .MAX_STALL(1)) dut1 (
        .Clock(Clock), .Reset(Reset),
        .Stall_PC(Stall_PC), .Stall_ID(Stall_ID), .Stall_ID_EX(Stall_ID_EX),
        .Branch_Taken(Branch_Taken),
        .IF_Instruction(IF_Instruction), .IF_PCPlus4(IF_PCPlus4), .ID_Ctrl(ID_Ctrl),
        .PC_Write(pcWrite1), .ID_Instruction(idInstr1), .ID_PCPlus4(idPc41),
        .EX_Ctrl(exCtrl1), .Stall_Count(stallCnt1), .Bubble_Count(bubbleCnt1),
        .Flush_Count(flushCnt1), .Stall_Timeout(timeout1)
    );

    task automatic applyStimulus(input logic rst, input logic spc, input logic sid,
                                 input logic sidex, input logic br,
                                 input logic [31:0] instr, input logic [31:0] pc4,
                                 input logic [15:0] ctrl);
        Reset          = rst;
        Stall_PC       = spc;
        Stall_ID       = sid;
        Stall_ID_EX    = sidex;
        Branch_Taken   = br;
        IF_Instruction = instr;
        IF_PCPlus4     = pc4;
        ID_Ctrl        = ctrl;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset with random inputs
        applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom, $urandom, 16'($urandom));
        tick();
        applyStimulus(1'b1, 1'b0, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom, $urandom, 16'($urandom));
        #1;
        checkOutput("rst_pcwrite", 64'(pcWrite0), 64'd0);
        tick();
        checkOutput("rst_idinstr", 64'(idInstr0), 64'd0);
        checkOutput("rst_idpc4", 64'(idPc40), 64'd0);
        checkOutput("rst_exctrl", 64'(exCtrl0), 64'd0);
        checkOutput("rst_stallcnt", 64'(stallCnt0), 64'd0);
        checkOutput("rst_bubblecnt", 64'(bubbleCnt0), 64'd0);
        checkOutput("rst_flushcnt", 64'(flushCnt0), 64'd0);
        checkOutput("rst_timeout", 64'(timeout0), 64'd0);
        checkOutput("rst_timeout_n", 64'(timeout1), 64'd0);

        // First load after reset
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8C220004, 32'h4, 16'h00A5);
        #1;
        checkOutput("run_pcwrite", 64'(pcWrite0), 64'd1);
        tick();
        checkOutput("load_instr", 64'(idInstr0), 64'h8C220004);
        checkOutput("load_pc4", 64'(idPc40), 64'h4);
        checkOutput("load_ctrl", 64'(exCtrl0), 64'h00A5);

        // All three stalls for one cycle
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h11111111, 32'h8, 16'h0F0F);
        #1;
        checkOutput("stall_pcwrite", 64'(pcWrite0), 64'd0);
        tick();
        checkOutput("stall_hold_instr", 64'(idInstr0), 64'h8C220004);
        checkOutput("stall_hold_pc4", 64'(idPc40), 64'h4);
        checkOutput("stall_bubble", 64'(exCtrl0), 64'd0);
        checkOutput("stall_cnt", 64'(stallCnt0), 64'd1);
        checkOutput("bubble_cnt", 64'(bubbleCnt0), 64'd1);
        checkOutput("stall_timeout", 64'(timeout0), 64'd0);
        checkOutput("max1_timeout", 64'(timeout1), 64'd1);

        // Branch flush without stall
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h22222222, 32'hC, 16'h1234);
        tick();
        checkOutput("flush_instr", 64'(idInstr0), 64'd0);
        checkOutput("flush_pc4", 64'(idPc40), 64'd0);
        checkOutput("flush_ctrl", 64'(exCtrl0), 64'h1234);
        checkOutput("flush_cnt", 64'(flushCnt0), 64'd1);
        checkOutput("flush_stallcnt", 64'(stallCnt0), 64'd1);

        // Reload, then a branch while IF/ID is stalled
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h44444444, 32'h10, 16'h0001);
        tick();
        checkOutput("reload_instr", 64'(idInstr0), 64'h44444444);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h55555555, 32'h14, 16'h00FF);
        tick();
        checkOutput("brstall_instr", 64'(idInstr0), 64'h44444444);
        checkOutput("brstall_pc4", 64'(idPc40), 64'h10);
        checkOutput("brstall_flushcnt", 64'(flushCnt0), 64'd1);
        checkOutput("brstall_ctrl", 64'(exCtrl0), 64'h00FF);
        checkOutput("brstall_stallcnt", 64'(stallCnt0), 64'd1);

        // Release, then Stall_PC for 15 cycles to trip the watchdog
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h66666666, 32'h18, 16'h0002);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h77777777, 32'h1C, 16'h0003);
        for (int i = 0; i < 14; i++) tick();
        checkOutput("wd14_timeout", 64'(timeout0), 64'd0);
        tick();
        checkOutput("wd15_timeout", 64'(timeout0), 64'd1);
        checkOutput("wd15_stallcnt", 64'(stallCnt0), 64'd16);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h88888888, 32'h20, 16'h0004);
        #1;
        checkOutput("wd_release_pcwrite", 64'(pcWrite0), 64'd1);
        tick();
        tick();
        checkOutput("wd_sticky", 64'(timeout0), 64'd1);

        // Reset, then 14 stall / 1 release / 14 stall keeps the watchdog quiet
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0);
        tick();
        checkOutput("rst2_timeout", 64'(timeout0), 64'd0);
        checkOutput("rst2_stallcnt", 64'(stallCnt0), 64'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0);
        for (int i = 0; i < 14; i++) tick();
        checkOutput("sat_pre_cnt", 64'(stallCnt1), 64'd14);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0);
        for (int i = 0; i < 14; i++) tick();
        checkOutput("split_timeout", 64'(timeout0), 64'd0);
        checkOutput("split_stallcnt", 64'(stallCnt0), 64'd28);
        checkOutput("sat_cnt", 64'(stallCnt1), 64'd15);
        tick();
        checkOutput("split15_timeout", 64'(timeout0), 64'd1);
        checkOutput("sat_hold_cnt", 64'(stallCnt1), 64'd15);

        // Reset in the middle of a stall clears everything
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0);
        #1;
        checkOutput("midrst_pcwrite", 64'(pcWrite0), 64'd0);
        tick();
        checkOutput("midrst_stallcnt", 64'(stallCnt0), 64'd0);
        checkOutput("midrst_stallcnt_n", 64'(stallCnt1), 64'd0);
        checkOutput("midrst_timeout", 64'(timeout0), 64'd0);
        checkOutput("midrst_timeout_n", 64'(timeout1), 64'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0);
        tick();
        checkOutput("post_rst_cnt", 64'(stallCnt0), 64'd1);
        checkOutput("post_rst_timeout", 64'(timeout0), 64'd0);
        checkOutput("post_rst_timeout_n", 64'(timeout1), 64'd1);

        // Bubble alone leaves the PC running
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h99999999, 32'h24, 16'hBEEF);
        #1;
        checkOutput("bubble_pcwrite", 64'(pcWrite0), 64'd1);
        tick();
        checkOutput("bubble_only_ctrl", 64'(exCtrl0), 64'd0);
        checkOutput("bubble_only_cnt", 64'(bubbleCnt0), 64'd1);
        checkOutput("bubble_only_stallcnt", 64'(stallCnt0), 64'd1);
        checkOutput("bubble_only_instr", 64'(idInstr0), 64'h99999999);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
